// File: rtl/es7243e_i2c_pkg.sv
// Shared types and constants for the ES7243E I2C write master.
package es7243e_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STA,
    ST_BIT,
    ST_ACK,
    ST_STP,
    ST_DONE,
    ST_WAIT
  } state_t;

  localparam int BYTES_PER_XFER = 3;
  localparam int BITS_PER_BYTE  = 8;
  localparam int QTR_DIV_DEF    = 30;

endpackage

// File: rtl/es7243e_i2c_wr_master_qtr_tick.sv
// Free-running quarter-period divider; one-cycle strobe on the last count.
module i2c_qtr_tick
  import es7243e_i2c_pkg::*;
#(
  parameter int QTR_DIV = QTR_DIV_DEF
) (
  input  logic clk_12M,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_12M) begin
    if (!rstn || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/es7243e_i2c_wr_master.sv
// Write-only I2C master: START, three bytes with ACK slots, STOP, per start request.
// Define I2C_NACK_RETRY_EN to re-attempt a NACKed word up to RETRY_MAX times.
//
// state | meaning
// IDLE  | bus free, waiting for a synced start rising edge
// STA   | SDA low with SCL high, 2 quarters
// BIT   | one data bit, 4 quarters, SDA set in q0
// ACK   | SDA released, slave sampled at end of q2
// STP   | SCL low/SDA low, SCL high/SDA low, SCL high/SDA released
// DONE  | tr_end high until start drops
// WAIT  | bus-free gap of 4 quarters before a retry
module es7243e_i2c_wr_master
  import es7243e_i2c_pkg::*;
#(
  parameter int QTR_DIV   = QTR_DIV_DEF,
  parameter int RETRY_MAX = 3
) (
  input  logic        clk_12M,
  input  logic        rstn,
  input  logic        start,
  input  logic [23:0] i2c_data,
  output logic        tr_end,
  output logic        ack,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  state_t      state;
  logic [1:0]  qtr;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic        result;
  logic        sda_low;
  logic        start_s1, start_s2, start_d;
  logic        sda_s1, sda_s2;
  logic        tick;
  logic        launch;

`ifdef I2C_NACK_RETRY_EN
  localparam int RCW = $clog2(RETRY_MAX + 2);
  logic [RCW-1:0] retry_cnt;
  logic [23:0]    word;
`else
  logic unused_retry;
  assign unused_retry = (RETRY_MAX != 0);
`endif

  always_ff @(posedge clk_12M) begin
    if (!rstn) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      sda_s1   <= i2c_sdat;
      sda_s2   <= sda_s1;
    end
  end

  assign launch = (state == ST_IDLE) && start_s2 && !start_d && !tr_end;

  i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_tick (
    .clk_12M (clk_12M),
    .rstn    (rstn),
    .clr     (launch),
    .tick    (tick)
  );

  // Open-drain: only ever pull low.
  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk_12M) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      qtr      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      result   <= 1'b0;
      i2c_sclk <= 1'b1;
      sda_low  <= 1'b0;
      tr_end   <= 1'b0;
      ack      <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
      retry_cnt <= '0;
      word      <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (launch) begin
            state    <= ST_STA;
            qtr      <= '0;
            byte_cnt <= '0;
            bit_cnt  <= 3'(BITS_PER_BYTE - 1);
            shreg    <= i2c_data;
            result   <= 1'b1;
            ack      <= 1'b0;
            sda_low  <= 1'b1;
`ifdef I2C_NACK_RETRY_EN
            word      <= i2c_data;
            retry_cnt <= '0;
`endif
          end
        end
        ST_STA: begin
          if (tick) begin
            if (qtr == 2'd1) begin
              state    <= ST_BIT;
              qtr      <= '0;
              i2c_sclk <= 1'b0;
              sda_low  <= ~shreg[23];
            end else begin
              qtr <= qtr + 2'd1;
            end
          end
        end
        ST_BIT: begin
          if (tick) begin
            case (qtr)
              2'd0: begin i2c_sclk <= 1'b1; qtr <= 2'd1; end
              2'd1: qtr <= 2'd2;
              2'd2: begin i2c_sclk <= 1'b0; qtr <= 2'd3; end
              default: begin
                shreg <= {shreg[22:0], 1'b0};
                qtr   <= '0;
                if (bit_cnt == 3'd0) begin
                  state   <= ST_ACK;
                  sda_low <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  sda_low <= ~shreg[22];
                end
              end
            endcase
          end
        end
        ST_ACK: begin
          if (tick) begin
            case (qtr)
              2'd0: begin i2c_sclk <= 1'b1; qtr <= 2'd1; end
              2'd1: qtr <= 2'd2;
              2'd2: begin
                i2c_sclk <= 1'b0;
                qtr      <= 2'd3;
                if (sda_s2) result <= 1'b0;
              end
              default: begin
                qtr <= '0;
                if (!result || byte_cnt == 2'(BYTES_PER_XFER - 1)) begin
                  state   <= ST_STP;
                  sda_low <= 1'b1;
                end else begin
                  state    <= ST_BIT;
                  byte_cnt <= byte_cnt + 2'd1;
                  bit_cnt  <= 3'(BITS_PER_BYTE - 1);
                  sda_low  <= ~shreg[23];
                end
              end
            endcase
          end
        end
        ST_STP: begin
          if (tick) begin
            case (qtr)
              2'd0: begin i2c_sclk <= 1'b1; qtr <= 2'd1; end
              2'd1: begin sda_low <= 1'b0; qtr <= 2'd2; end
              default: begin
                qtr <= '0;
`ifdef I2C_NACK_RETRY_EN
                if (!result && retry_cnt < RCW'(RETRY_MAX)) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  state     <= ST_WAIT;
                end else begin
                  state  <= ST_DONE;
                  tr_end <= 1'b1;
                  ack    <= result;
                end
`else
                state  <= ST_DONE;
                tr_end <= 1'b1;
                ack    <= result;
`endif
              end
            endcase
          end
        end
        ST_DONE: begin
          if (tick && !start_s2) begin
            tr_end <= 1'b0;
            state  <= ST_IDLE;
          end
        end
`ifdef I2C_NACK_RETRY_EN
        ST_WAIT: begin
          if (tick) begin
            if (qtr == 2'd3) begin
              state    <= ST_STA;
              qtr      <= '0;
              byte_cnt <= '0;
              bit_cnt  <= 3'(BITS_PER_BYTE - 1);
              shreg    <= word;
              result   <= 1'b1;
              sda_low  <= 1'b1;
            end else begin
              qtr <= qtr + 2'd1;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_es7243e_i2c_wr_master.sv
// Scoreboard bench: I2C slave model on pulled-up SDA plus tr_end/ack monitor.
module tb_es7243e_i2c_wr_master;

  logic        clk_12M  = 1'b0;
  logic        rstn     = 1'b0;
  logic        start    = 1'b0;
  logic [23:0] i2c_data = '0;
  logic        tr_end, ack, i2c_sclk;
  logic        bfm_low  = 1'b0;
  wire         sda;

  pullup (sda);
  assign sda = bfm_low ? 1'b0 : 1'bz;

  always #5 clk_12M = ~clk_12M;

  es7243e_i2c_wr_master dut (
    .clk_12M  (clk_12M),
    .rstn     (rstn),
    .start    (start),
    .i2c_data (i2c_data),
    .tr_end   (tr_end),
    .ack      (ack),
    .i2c_sclk (i2c_sclk),
    .i2c_sdat (sda)
  );

`ifdef I2C_NACK_RETRY_EN
  localparam int NACK_ATTEMPTS = 4;
`else
  localparam int NACK_ATTEMPTS = 1;
`endif

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int nack_until = 0;
  int abort_gen = 0;
  int exp_byte_q[$];
  int exp_pulse_q[$];
  int exp_ack_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_12M);
  endtask

  task automatic push_ok(input logic [23:0] d);
    exp_byte_q.push_back(int'(d[23:16]));
    exp_byte_q.push_back(int'(d[15:8]));
    exp_byte_q.push_back(int'(d[7:0]));
    exp_pulse_q.push_back(27);
  endtask

  task automatic push_nack(input logic [23:0] d);
    exp_byte_q.push_back(int'(d[23:16]));
    exp_pulse_q.push_back(9);
  endtask

  // Slave model: decodes START/STOP, collects bytes, drives ACK, checks SCL timing.
  task automatic bfm_run();
    logic ps, pd, cs, cd;
    logic [7:0] sh;
    int seen, rises, bitpos, byte_idx, last_rise, t;
    bit in_xfer;
    ps = 1'b1; pd = 1'b1; sh = '0;
    seen = 0; rises = 0; bitpos = 0; byte_idx = 0; last_rise = 0; t = 0; in_xfer = 0;
    forever begin
      @(negedge clk_12M);
      t++;
      cs = i2c_sclk;
      cd = sda;
      if (seen != abort_gen) begin
        seen = abort_gen;
        in_xfer = 0;
        bfm_low = 1'b0;
      end else if (ps && cs && pd && !cd) begin
        check("start_only_when_idle", int'(in_xfer), 0);
        in_xfer = 1; start_cnt++;
        rises = 0; bitpos = 0; byte_idx = 0;
      end else if (ps && cs && !pd && cd) begin
        if (in_xfer) begin
          check("stop_after_ack_slot", bitpos, 1);
          check("pulse_count_expected", int'(exp_pulse_q.size() > 0), 1);
          if (exp_pulse_q.size() > 0) check("scl_pulse_count", rises - 1, exp_pulse_q.pop_front());
          in_xfer = 0;
        end
      end else if (in_xfer && !ps && cs) begin
        if (rises > 0) check("scl_period", t - last_rise, 120);
        rises++;
        last_rise = t;
        if (bitpos < 8) begin
          sh = {sh[6:0], cd};
          bitpos++;
        end else begin
          bitpos = 9;
        end
      end else if (in_xfer && ps && !cs) begin
        if (rises > 0) check("scl_high_time", t - last_rise, 60);
        if (bitpos == 8) begin
          bfm_low = !(byte_idx == 0 && start_cnt <= nack_until);
        end else if (bitpos == 9) begin
          bfm_low = 1'b0;
          check("byte_expected", int'(exp_byte_q.size() > 0), 1);
          if (exp_byte_q.size() > 0) check("byte_value", int'(sh), exp_byte_q.pop_front());
          byte_idx++;
          bitpos = 0;
        end
      end
      ps = cs;
      pd = cd;
    end
  endtask

  task automatic mon_run();
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_12M);
      if (tr_end && !prev) begin
        check("tr_end_expected", int'(exp_ack_q.size() > 0), 1);
        if (exp_ack_q.size() > 0) check("ack_result", int'(ack), exp_ack_q.pop_front());
      end
      prev = tr_end;
    end
  endtask

  task automatic run_xfer(input logic [23:0] d, input bit scramble, input int limit, output int lat);
    @(negedge clk_12M);
    i2c_data = d;
    start = 1'b1;
    lat = 0;
    while (!tr_end && lat < limit) begin
      @(negedge clk_12M);
      lat++;
      if (scramble && lat == 600) i2c_data = 24'hFF_FFFF;
    end
    check("tr_end_in_time", int'(tr_end), 1);
  endtask

  task automatic end_xfer();
    int n;
    n = 0;
    start = 1'b0;
    while (tr_end && n < 200) begin
      @(negedge clk_12M);
      n++;
    end
    check("tr_end_cleared", int'(tr_end), 0);
    wait_clk(100);
  endtask

  initial begin
    int lat, s;
    fork
      bfm_run();
      mon_run();
    join_none

    wait_clk(5);
    check("reset_sclk", int'(i2c_sclk), 1);
    check("reset_sdat", int'(sda), 1);
    check("reset_tr_end", int'(tr_end), 0);
    check("reset_ack", int'(ack), 0);
    rstn = 1'b1;
    wait_clk(50);

    // Plain write, all ACKed, with end-to-end latency
    push_ok(24'h20_013A);
    exp_ack_q.push_back(1);
    run_xfer(24'h20_013A, 1'b0, 5000, lat);
    check("latency_window", int'(lat >= 3389 && lat <= 3393), 1);
    end_xfer();

    // Address NACK
    nack_until = start_cnt + NACK_ATTEMPTS;
    repeat (NACK_ATTEMPTS) push_nack(24'h20_013A);
    exp_ack_q.push_back(0);
    run_xfer(24'h20_013A, 1'b0, 20000, lat);
    end_xfer();

    // start held high after tr_end must not relaunch
    push_ok(24'h20_0A55);
    exp_ack_q.push_back(1);
    run_xfer(24'h20_0A55, 1'b0, 5000, lat);
    s = start_cnt;
    wait_clk(10000);
    check("no_relaunch_starts", start_cnt, s);
    check("tr_end_held", int'(tr_end), 1);
    end_xfer();
    push_ok(24'h20_1600);
    exp_ack_q.push_back(1);
    run_xfer(24'h20_1600, 1'b1, 5000, lat);
    end_xfer();

    // Reset in byte 1, bit 4, q3 (SCL low, SDA low)
    exp_byte_q.push_back(8'h20);
    @(negedge clk_12M);
    i2c_data = 24'h20_013A;
    start = 1'b1;
    wait_clk(1725);
    check("pre_abort_sclk", int'(i2c_sclk), 0);
    check("pre_abort_sdat", int'(sda), 0);
    abort_gen++;
    @(negedge clk_12M);
    rstn = 1'b0;
    start = 1'b0;
    @(negedge clk_12M);
    check("abort_sclk", int'(i2c_sclk), 1);
    check("abort_sdat", int'(sda), 1);
    check("abort_tr_end", int'(tr_end), 0);
    rstn = 1'b1;
    wait_clk(100);

    push_ok(24'h20_0C3F);
    exp_ack_q.push_back(1);
    run_xfer(24'h20_0C3F, 1'b0, 5000, lat);
    check("latency_after_abort", int'(lat >= 3389 && lat <= 3393), 1);
    end_xfer();

`ifdef I2C_NACK_RETRY_EN
    s = start_cnt;
    nack_until = start_cnt + 2;
    push_nack(24'h20_0102);
    push_nack(24'h20_0102);
    push_ok(24'h20_0102);
    exp_ack_q.push_back(1);
    run_xfer(24'h20_0102, 1'b0, 20000, lat);
    check("retry_start_count_ok", start_cnt - s, 3);
    end_xfer();

    s = start_cnt;
    nack_until = start_cnt + 4;
    repeat (4) push_nack(24'h20_0102);
    exp_ack_q.push_back(0);
    run_xfer(24'h20_0102, 1'b0, 20000, lat);
    check("retry_start_count_fail", start_cnt - s, 4);
    end_xfer();
`endif

    wait_clk(200);
    check("bytes_drained", exp_byte_q.size(), 0);
    check("pulses_drained", exp_pulse_q.size(), 0);
    check("acks_drained", exp_ack_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
